cdc_txn_scheduler: RTL and testbench

//  clk-domain scheduler in front of the AR/R/AW/W/B asynchronous CDC FIFO bundle. Arbitrates two

---
 rtl/cdc_txn_scheduler.sv | 239 +++++++++++++++++++++++
 tb/tb_cdc_txn_scheduler.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_txn_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : cdc_txn_scheduler
// Brief    : Clock-domain scheduler in front of an AR/AW/W/R/B async FIFO
//            bundle. Round-robin arbitration of two local masters into AR or
//            AW+W pushes; R/B responses are popped and routed back by id[0].
// Revision : 1.0 - initial release
// ============================================================================
module cdc_txn_scheduler #(
  parameter int         MAX_OUT = 4,
  parameter logic [3:0] ID_TAG  = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  // master 0 (fetch)
  input  logic        m0_req_valid,
  input  logic        m0_req_write,
  input  logic [31:0] m0_req_addr,
  input  logic [3:0]  m0_req_len,
  input  logic [2:0]  m0_req_size,
  output logic        m0_req_ready,
  input  logic        m0_wvalid,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_wready,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic [1:0]  m0_rresp,
  output logic        m0_rlast,
  output logic        m0_bvalid,
  output logic [1:0]  m0_bresp,
  // master 1 (load/store)
  input  logic        m1_req_valid,
  input  logic        m1_req_write,
  input  logic [31:0] m1_req_addr,
  input  logic [3:0]  m1_req_len,
  input  logic [2:0]  m1_req_size,
  output logic        m1_req_ready,
  input  logic        m1_wvalid,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_wready,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [1:0]  m1_rresp,
  output logic        m1_rlast,
  output logic        m1_bvalid,
  output logic [1:0]  m1_bresp,
  // FIFO bundle, near side
  input  logic        AR_not_full,
  input  logic        AW_not_full,
  input  logic        W_not_full,
  output logic        AR_wr_en,
  output logic [48:0] AR_w_data,
  output logic        AW_wr_en,
  output logic [48:0] AW_w_data,
  output logic        W_wr_en,
  output logic [36:0] W_w_data,
  input  logic        R_not_empty,
  input  logic [42:0] R_r_data,
  output logic        R_rd_en,
  input  logic        B_not_empty,
  input  logic [9:0]  B_r_data,
  output logic        B_rd_en
);

  localparam logic [3:0] CNT_MAX    = 4'(MAX_OUT);
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARB     = 3'd1,
    PUSH_AR = 3'd2,
    PUSH_AW = 3'd3,
    PUSH_W  = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic        gnt, gnt_nxt;
  logic        rr, rr_nxt;
  logic [3:0]  beat, beat_nxt;
  logic [3:0]  wlen, wlen_nxt;
  logic [3:0]  cnt0, cnt1;
  logic        elig0, elig1, accept, w_fire;

  logic [31:0] g_addr, g_wdata;
  logic [3:0]  g_len, g_wstrb;
  logic [2:0]  g_size;
  logic        g_wvalid, w_last;
  logic [7:0]  req_id;
  logic [48:0] req_pkt;

  // A master competes only while it has headroom for another outstanding txn
  assign elig0 = m0_req_valid && (cnt0 < CNT_MAX);
  assign elig1 = m1_req_valid && (cnt1 < CNT_MAX);

  // Fields of the granted master; masters hold them stable until accepted
  assign g_addr   = gnt ? m1_req_addr : m0_req_addr;
  assign g_len    = gnt ? m1_req_len  : m0_req_len;
  assign g_size   = gnt ? m1_req_size : m0_req_size;
  assign g_wvalid = gnt ? m1_wvalid   : m0_wvalid;
  assign g_wdata  = gnt ? m1_wdata    : m0_wdata;
  assign g_wstrb  = gnt ? m1_wstrb    : m0_wstrb;
  assign req_id   = {ID_TAG, 3'b000, gnt};
  assign req_pkt  = {req_id, g_addr, g_len, g_size, BURST_INCR};
  assign w_last   = (beat == wlen);

  // State, grant, round-robin pointer and write-beat tracking registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt   <= 1'b0;
      rr    <= 1'b0;
      beat  <= 4'd0;
      wlen  <= 4'd0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      rr    <= rr_nxt;
      beat  <= beat_nxt;
      wlen  <= wlen_nxt;
    end
  end

  // Next-state and request-side outputs
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    rr_nxt    = rr;
    beat_nxt  = beat;
    wlen_nxt  = wlen;
    accept    = 1'b0;
    w_fire    = 1'b0;
    AR_wr_en  = 1'b0;
    AW_wr_en  = 1'b0;
    W_wr_en   = 1'b0;
    AR_w_data = '0;
    AW_w_data = '0;
    W_w_data  = '0;
    case (state)
      IDLE: begin
        if (elig0 || elig1) state_nxt = ARB;
      end
      ARB: begin
        if (elig0 || elig1) begin
          if (elig0 && elig1) gnt_nxt = rr;
          else                gnt_nxt = elig1;
          rr_nxt = ~gnt_nxt;
          if (gnt_nxt ? m1_req_write : m0_req_write) state_nxt = PUSH_AW;
          else                                        state_nxt = PUSH_AR;
        end else begin
          state_nxt = IDLE;
        end
      end
      PUSH_AR: begin
        AR_w_data = req_pkt;
        if (AR_not_full) begin
          AR_wr_en  = 1'b1;
          accept    = 1'b1;
          state_nxt = IDLE;
        end
      end
      PUSH_AW: begin
        AW_w_data = req_pkt;
        if (AW_not_full) begin
          AW_wr_en  = 1'b1;
          accept    = 1'b1;
          wlen_nxt  = g_len;
          beat_nxt  = 4'd0;
          state_nxt = PUSH_W;
        end
      end
      PUSH_W: begin
        W_w_data = {g_wdata, g_wstrb, w_last};
        w_fire   = g_wvalid && W_not_full;
        W_wr_en  = w_fire;
        if (w_fire) begin
          if (w_last) state_nxt = IDLE;
          else        beat_nxt  = beat + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign m0_req_ready = accept && !gnt;
  assign m1_req_ready = accept &&  gnt;
  assign m0_wready    = w_fire && !gnt;
  assign m1_wready    = w_fire &&  gnt;

  // Response path: show-ahead FIFOs are drained unconditionally
  logic r_sel, b_sel, r_last;
  logic unused_id_bits;

  assign r_sel   = R_r_data[35];
  assign r_last  = R_r_data[0];
  assign b_sel   = B_r_data[2];
  assign R_rd_en = R_not_empty;
  assign B_rd_en = B_not_empty;
  assign unused_id_bits = ^{R_r_data[42:36], B_r_data[9:3]};

  assign m0_rvalid = R_not_empty && !r_sel;
  assign m1_rvalid = R_not_empty &&  r_sel;
  assign m0_rdata  = m0_rvalid ? R_r_data[34:3] : 32'd0;
  assign m1_rdata  = m1_rvalid ? R_r_data[34:3] : 32'd0;
  assign m0_rresp  = m0_rvalid ? R_r_data[2:1]  : 2'd0;
  assign m1_rresp  = m1_rvalid ? R_r_data[2:1]  : 2'd0;
  assign m0_rlast  = m0_rvalid && r_last;
  assign m1_rlast  = m1_rvalid && r_last;
  assign m0_bvalid = B_not_empty && !b_sel;
  assign m1_bvalid = B_not_empty &&  b_sel;
  assign m0_bresp  = m0_bvalid ? B_r_data[1:0] : 2'd0;
  assign m1_bresp  = m1_bvalid ? B_r_data[1:0] : 2'd0;

  // Outstanding count: +1 on accept, -1 per R last and per B; floor at zero
  function automatic logic [3:0] cnt_update(input logic [3:0] c, input logic inc,
                                            input logic r_dec, input logic b_dec);
    logic [4:0] up;
    logic [4:0] dn;
    logic [4:0] res;
    up  = {1'b0, c} + {4'd0, inc};
    dn  = {4'd0, r_dec} + {4'd0, b_dec};
    res = (up >= dn) ? (up - dn) : 5'd0;
    return res[3:0];
  endfunction

  // Per-master outstanding transaction counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt0 <= 4'd0;
      cnt1 <= 4'd0;
    end else begin
      cnt0 <= cnt_update(cnt0, m0_req_ready, m0_rlast, m0_bvalid);
      cnt1 <= cnt_update(cnt1, m1_req_ready, m1_rlast, m1_bvalid);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdc_txn_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdc_txn_scheduler
// Brief    : Directed stimulus with a queue scoreboard for cdc_txn_scheduler
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdc_txn_scheduler;
  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m0_req_valid, m0_req_write, m0_req_ready, m0_wvalid, m0_wready;
  logic [31:0] m0_req_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_req_len, m0_wstrb;
  logic [2:0]  m0_req_size;
  logic        m0_rvalid, m0_rlast, m0_bvalid;
  logic [1:0]  m0_rresp, m0_bresp;
  logic        m1_req_valid, m1_req_write, m1_req_ready, m1_wvalid, m1_wready;
  logic [31:0] m1_req_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_req_len, m1_wstrb;
  logic [2:0]  m1_req_size;
  logic        m1_rvalid, m1_rlast, m1_bvalid;
  logic [1:0]  m1_rresp, m1_bresp;
  logic        AR_not_full, AW_not_full, W_not_full;
  logic        AR_wr_en, AW_wr_en, W_wr_en;
  logic [48:0] AR_w_data, AW_w_data;
  logic [36:0] W_w_data;
  logic        R_not_empty, R_rd_en, B_not_empty, B_rd_en;
  logic [42:0] R_r_data;
  logic [9:0]  B_r_data;

  cdc_txn_scheduler #(.MAX_OUT(MAX_OUT), .ID_TAG(4'h0)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_write(m0_req_write), .m0_req_addr(m0_req_addr),
    .m0_req_len(m0_req_len), .m0_req_size(m0_req_size), .m0_req_ready(m0_req_ready),
    .m0_wvalid(m0_wvalid), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wready(m0_wready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m0_bvalid(m0_bvalid), .m0_bresp(m0_bresp),
    .m1_req_valid(m1_req_valid), .m1_req_write(m1_req_write), .m1_req_addr(m1_req_addr),
    .m1_req_len(m1_req_len), .m1_req_size(m1_req_size), .m1_req_ready(m1_req_ready),
    .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wready(m1_wready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp),
    .AR_not_full(AR_not_full), .AW_not_full(AW_not_full), .W_not_full(W_not_full),
    .AR_wr_en(AR_wr_en), .AR_w_data(AR_w_data), .AW_wr_en(AW_wr_en), .AW_w_data(AW_w_data),
    .W_wr_en(W_wr_en), .W_w_data(W_w_data),
    .R_not_empty(R_not_empty), .R_r_data(R_r_data), .R_rd_en(R_rd_en),
    .B_not_empty(B_not_empty), .B_r_data(B_r_data), .B_rd_en(B_rd_en)
  );

  logic [221:0] all_out;
  assign all_out = {m0_req_ready, m0_wready, m0_rvalid, m0_rdata, m0_rresp, m0_rlast,
                    m0_bvalid, m0_bresp, m1_req_ready, m1_wready, m1_rvalid, m1_rdata,
                    m1_rresp, m1_rlast, m1_bvalid, m1_bresp, AR_wr_en, AR_w_data,
                    AW_wr_en, AW_w_data, W_wr_en, W_w_data, R_rd_en, B_rd_en};

  int total = 0;
  int bad   = 0;

  logic [48:0] ar_q[$];
  logic [48:0] aw_q[$];
  logic [36:0] w_q[$];
  logic [34:0] r0_q[$];
  logic [34:0] r1_q[$];
  logic [1:0]  b0_q[$];
  logic [1:0]  b1_q[$];
  logic [31:0] wd[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    total++;
    bad++;
    $display("FAIL %s: got=%0h want=no-output at %0t", name, act, $time);
  endtask

  // Monitor: every DUT push/response pops its expected entry
  always @(negedge clk) begin
    if (rst) begin
      if (AR_wr_en) begin
        if (ar_q.size() == 0) unexpected("ar_push", 64'(AR_w_data));
        else check("ar_push", 64'(AR_w_data), 64'(ar_q.pop_front()));
      end
      if (AW_wr_en) begin
        if (aw_q.size() == 0) unexpected("aw_push", 64'(AW_w_data));
        else check("aw_push", 64'(AW_w_data), 64'(aw_q.pop_front()));
      end
      if (W_wr_en) begin
        if (w_q.size() == 0) unexpected("w_push", 64'(W_w_data));
        else check("w_push", 64'(W_w_data), 64'(w_q.pop_front()));
      end
      if (m0_rvalid) begin
        if (r0_q.size() == 0) unexpected("m0_r", 64'(m0_rdata));
        else check("m0_r", 64'({m0_rdata, m0_rresp, m0_rlast}), 64'(r0_q.pop_front()));
      end
      if (m1_rvalid) begin
        if (r1_q.size() == 0) unexpected("m1_r", 64'(m1_rdata));
        else check("m1_r", 64'({m1_rdata, m1_rresp, m1_rlast}), 64'(r1_q.pop_front()));
      end
      if (m0_bvalid) begin
        if (b0_q.size() == 0) unexpected("m0_b", 64'(m0_bresp));
        else check("m0_b", 64'(m0_bresp), 64'(b0_q.pop_front()));
      end
      if (m1_bvalid) begin
        if (b1_q.size() == 0) unexpected("m1_b", 64'(m1_bresp));
        else check("m1_b", 64'(m1_bresp), 64'(b1_q.pop_front()));
      end
      check("cnt_range", 64'((dut.cnt0 <= 4'(MAX_OUT)) && (dut.cnt1 <= 4'(MAX_OUT))), 64'd1);
    end
  end

  task automatic set_req(input int m, input logic v, input logic wr,
                         input logic [31:0] a, input logic [3:0] l);
    if (m == 0) begin
      m0_req_valid = v; m0_req_write = wr; m0_req_addr = a; m0_req_len = l; m0_req_size = 3'd2;
    end else begin
      m1_req_valid = v; m1_req_write = wr; m1_req_addr = a; m1_req_len = l; m1_req_size = 3'd2;
    end
  endtask

  task automatic set_w(input int m, input logic v, input logic [31:0] d);
    if (m == 0) begin m0_wvalid = v; m0_wdata = d; m0_wstrb = 4'hF; end
    else        begin m1_wvalid = v; m1_wdata = d; m1_wstrb = 4'hF; end
  endtask

  // Counts negedges until the selected handshake is seen; -1 on timeout
  task automatic wait_hs(input int m, input bit wch, input int bound, output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (wch ? (m == 0 ? m0_wready : m1_wready) : (m == 0 ? m0_req_ready : m1_req_ready))
        return;
      if (cyc >= bound) begin
        cyc = -1;
        return;
      end
    end
  endtask

  task automatic issue_read(input int m, input logic [31:0] a, input logic [3:0] l, output int cyc);
    ar_q.push_back({8'(m), a, l, 3'd2, 2'b01});
    @(posedge clk); #1;
    set_req(m, 1'b1, 1'b0, a, l);
    wait_hs(m, 1'b0, 30, cyc);
    check("read_accepted", 64'(cyc > 0), 64'd1);
    @(posedge clk); #1;
    set_req(m, 1'b0, 1'b0, 32'd0, 4'd0);
  endtask

  task automatic do_write(input int m, input logic [31:0] a, input logic [3:0] l);
    int c;
    aw_q.push_back({8'(m), a, l, 3'd2, 2'b01});
    for (int b = 0; b <= int'(l); b++) w_q.push_back({wd[b], 4'hF, (b == int'(l))});
    @(posedge clk); #1;
    set_req(m, 1'b1, 1'b1, a, l);
    wait_hs(m, 1'b0, 30, c);
    check("write_accepted", 64'(c > 0), 64'd1);
    @(posedge clk); #1;
    set_req(m, 1'b0, 1'b0, 32'd0, 4'd0);
    for (int b = 0; b <= int'(l); b++) begin
      set_w(m, 1'b1, wd[b]);
      wait_hs(m, 1'b1, 30, c);
      check("wbeat_accepted", 64'(c > 0), 64'd1);
      @(posedge clk); #1;
    end
    set_w(m, 1'b0, 32'd0);
  endtask

  task automatic send_r(input logic [7:0] id, input logic [31:0] d, input logic [1:0] rs, input logic last);
    if (id[0]) r1_q.push_back({d, rs, last});
    else       r0_q.push_back({d, rs, last});
    @(posedge clk); #1;
    R_not_empty = 1'b1;
    R_r_data    = {id, d, rs, last};
    @(posedge clk); #1;
    R_not_empty = 1'b0;
    R_r_data    = '0;
  endtask

  task automatic send_b(input logic [7:0] id, input logic [1:0] rs);
    if (id[0]) b1_q.push_back(rs);
    else       b0_q.push_back(rs);
    @(posedge clk); #1;
    B_not_empty = 1'b1;
    B_r_data    = {id, rs};
    @(posedge clk); #1;
    B_not_empty = 1'b0;
    B_r_data    = '0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, seen, mism;
    logic [48:0] pkt;

    rst = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'd0, 4'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 4'd0);
    set_w(0, 1'b0, 32'd0);
    set_w(1, 1'b0, 32'd0);
    AR_not_full = 1'b1; AW_not_full = 1'b1; W_not_full = 1'b1;
    R_not_empty = 1'b0; R_r_data = '0;
    B_not_empty = 1'b0; B_r_data = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(|all_out), 64'd0);
    check("reset_cnt", 64'({dut.cnt0, dut.cnt1}), 64'd0);
    check("reset_state", 64'(dut.state), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // 1: M0 read, len 3, four R beats, counter returns to zero
    issue_read(0, 32'h0000_1000, 4'd3, c);
    check("t1_latency_negedges", 64'(c), 64'd3);
    check("t1_cnt_after_accept", 64'(dut.cnt0), 64'd1);
    for (int i = 0; i < 4; i++) send_r(8'h00, 32'h1111_0000 + 32'(i), 2'b00, (i == 3));
    check("t1_cnt_after_rlast", 64'(dut.cnt0), 64'd0);

    // 2: M1 write, len 1, then B response
    wd[0] = 32'hA5A5_A5A5; wd[1] = 32'h5A5A_5A5A;
    do_write(1, 32'h0000_2000, 4'd1);
    check("t2_cnt1_outstanding", 64'(dut.cnt1), 64'd1);
    send_b(8'h01, 2'b00);
    check("t2_cnt1_after_b", 64'(dut.cnt1), 64'd0);

    // 3: continuous contention, grants alternate M0,M1,M0,M1
    ar_q.push_back({8'h00, 32'h3000, 4'd0, 3'd2, 2'b01});
    ar_q.push_back({8'h01, 32'h4000, 4'd0, 3'd2, 2'b01});
    ar_q.push_back({8'h00, 32'h3004, 4'd0, 3'd2, 2'b01});
    ar_q.push_back({8'h01, 32'h4004, 4'd0, 3'd2, 2'b01});
    @(posedge clk); #1;
    fork
      begin
        int cc;
        set_req(0, 1'b1, 1'b0, 32'h3000, 4'd0);
        for (int k = 0; k < 2; k++) begin
          wait_hs(0, 1'b0, 40, cc);
          check("t3_m0_accept", 64'(cc > 0), 64'd1);
          @(posedge clk); #1;
          if (k == 0) set_req(0, 1'b1, 1'b0, 32'h3004, 4'd0);
          else        set_req(0, 1'b0, 1'b0, 32'd0, 4'd0);
        end
      end
      begin
        int cc;
        set_req(1, 1'b1, 1'b0, 32'h4000, 4'd0);
        for (int k = 0; k < 2; k++) begin
          wait_hs(1, 1'b0, 40, cc);
          check("t3_m1_accept", 64'(cc > 0), 64'd1);
          @(posedge clk); #1;
          if (k == 0) set_req(1, 1'b1, 1'b0, 32'h4004, 4'd0);
          else        set_req(1, 1'b0, 1'b0, 32'd0, 4'd0);
        end
      end
    join
    check("t3_ar_all_seen", 64'(ar_q.size()), 64'd0);
    send_r(8'h00, 32'hC0C0_0001, 2'b00, 1'b1);
    send_r(8'h01, 32'hC1C1_0001, 2'b01, 1'b1);
    send_r(8'h00, 32'hC0C0_0002, 2'b10, 1'b1);
    send_r(8'h01, 32'hC1C1_0002, 2'b00, 1'b1);
    check("t3_cnt_drained", 64'({dut.cnt0, dut.cnt1}), 64'd0);

    // 4: MAX_OUT outstanding blocks the fifth read until one completes
    for (int i = 0; i < 4; i++) issue_read(0, 32'h5000 + 32'(4 * i), 4'd0, c);
    check("t4_cnt_full", 64'(dut.cnt0), 64'(MAX_OUT));
    ar_q.push_back({8'h00, 32'h5010, 4'd0, 3'd2, 2'b01});
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 32'h5010, 4'd0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (m0_req_ready || AR_wr_en) seen++;
    end
    check("t4_fifth_held", 64'(seen), 64'd0);
    send_r(8'h00, 32'hD000_0000, 2'b00, 1'b1);
    wait_hs(0, 1'b0, 3, c);
    check("t4_release_within_3", 64'(c > 0), 64'd1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 32'd0, 4'd0);
    for (int i = 0; i < 4; i++) send_r(8'h00, 32'hD000_0001 + 32'(i), 2'b00, 1'b1);
    check("t4_cnt_drained", 64'(dut.cnt0), 64'd0);

    // 5: AR FIFO full holds the push with stable fields
    pkt = {8'h01, 32'h6000, 4'd0, 3'd2, 2'b01};
    ar_q.push_back(pkt);
    @(posedge clk); #1;
    AR_not_full = 1'b0;
    set_req(1, 1'b1, 1'b0, 32'h6000, 4'd0);
    seen = 0;
    mism = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (AR_wr_en || m1_req_ready) seen++;
      if (i >= 2 && AR_w_data !== pkt) mism++;
    end
    check("t5_no_push_while_full", 64'(seen), 64'd0);
    check("t5_fields_stable", 64'(mism), 64'd0);
    @(posedge clk); #1;
    AR_not_full = 1'b1;
    wait_hs(1, 1'b0, 2, c);
    check("t5_push_on_space", 64'(c), 64'd1);
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, 32'd0, 4'd0);
    send_r(8'h01, 32'hE000_0000, 2'b00, 1'b1);

    // 6: reset during second beat of a 4-beat write
    wd[0] = 32'h0102_0304; wd[1] = 32'h1112_1314; wd[2] = 32'h2122_2324; wd[3] = 32'h3132_3334;
    aw_q.push_back({8'h00, 32'h7000, 4'd3, 3'd2, 2'b01});
    w_q.push_back({wd[0], 4'hF, 1'b0});
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b1, 32'h7000, 4'd3);
    wait_hs(0, 1'b0, 30, c);
    check("t6_aw_accept", 64'(c > 0), 64'd1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 32'd0, 4'd0);
    set_w(0, 1'b1, wd[0]);
    wait_hs(0, 1'b1, 30, c);
    check("t6_beat0", 64'(c > 0), 64'd1);
    @(posedge clk); #1;
    set_w(0, 1'b1, wd[1]);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("t6_outputs_zero", 64'(|all_out), 64'd0);
    check("t6_cnt_zero", 64'({dut.cnt0, dut.cnt1}), 64'd0);
    set_w(0, 1'b0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_idle_after_release", 64'(dut.state), 64'd0);
    check("t6_w_abandoned", 64'(w_q.size()), 64'd0);

    // Unmatched response: forwarded, counter floors at zero
    send_b(8'h00, 2'b10);
    check("unmatched_b_cnt", 64'(dut.cnt0), 64'd0);

    // Recovery after reset
    issue_read(1, 32'h0000_8000, 4'd0, c);
    send_r(8'h01, 32'hF00D_F00D, 2'b11, 1'b1);
    repeat (2) @(negedge clk);
    check("queues_empty", 64'(ar_q.size() + aw_q.size() + w_q.size() + r0_q.size()
                              + r1_q.size() + b0_q.size() + b1_q.size()), 64'd0);
    check("final_cnt", 64'({dut.cnt0, dut.cnt1}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
